// File: rtl/ex_mem_skid.sv
// ex_mem_skid: registered two-entry skid buffer between the execute and memory stages.
// Carries {dest reg addr, result data, write enable} with valid/ready on both sides.
// ex_ready comes straight from a flop, so there is no combinational path from mem_ready.
// Optional feature macro: EX_MEM_PERF_CNT_EN adds the saturating stall_cnt port and counter.
// Ports:
//   clk, rst_n                        clock, asynchronous active-low reset
//   flush                             synchronous flush, drops held and incoming entries
//   ex_valid / ex_ready               upstream handshake (ex_ready registered)
//   w_reg_addr_in/data_in/en_in       upstream payload
//   mem_valid / mem_ready             downstream handshake
//   w_reg_addr_out/data_out/en_out    downstream payload (en gated by mem_valid)
//   stall_cnt                         ex stall cycles, saturating (EX_MEM_PERF_CNT_EN only)

`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 5
`endif
`ifndef REG_DATA_WIDTH
`define REG_DATA_WIDTH 32
`endif

module ex_mem_skid #(
   parameter int unsigned ADDR_W = `REG_ADDR_WIDTH,
   parameter int unsigned DATA_W = `REG_DATA_WIDTH
`ifdef EX_MEM_PERF_CNT_EN
   ,
   parameter int unsigned CNT_W  = 16
`endif
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              ex_valid,
   output logic              ex_ready,
   input  logic [ADDR_W-1:0] w_reg_addr_in,
   input  logic [DATA_W-1:0] w_reg_data_in,
   input  logic              w_reg_en_in,
   output logic              mem_valid,
   input  logic              mem_ready,
   output logic [ADDR_W-1:0] w_reg_addr_out,
   output logic [DATA_W-1:0] w_reg_data_out,
   output logic              w_reg_en_out
`ifdef EX_MEM_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0]  stall_cnt
`endif
);

   // State encoding is {skid_v, out_v}; 2'b10 cannot be reached.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'b00,
      ST_ONE   = 2'b01,
      ST_FULL  = 2'b11
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   skid_addr_q, skid_addr_d;
   logic [DATA_W-1:0]   skid_data_q, skid_data_d;
   logic                skid_en_q, skid_en_d;
   logic [ADDR_W-1:0]   out_addr_d;
   logic [DATA_W-1:0]   out_data_d;
   logic                out_en_d;
   logic                ex_ready_d;
   logic                accept;
   logic                pop;

   assign mem_valid = state_q[0];
   assign accept    = ex_valid & ex_ready;
   assign pop       = mem_valid & mem_ready;

   // State and payload registers; out_en is kept cleared whenever the OUT slot is empty.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= ST_EMPTY;
         ex_ready       <= 1'b1;
         w_reg_addr_out <= '0;
         w_reg_data_out <= '0;
         w_reg_en_out   <= 1'b0;
         skid_addr_q    <= '0;
         skid_data_q    <= '0;
         skid_en_q      <= 1'b0;
      end else begin
         state_q        <= state_d;
         ex_ready       <= ex_ready_d;
         w_reg_addr_out <= out_addr_d;
         w_reg_data_out <= out_data_d;
         w_reg_en_out   <= out_en_d;
         skid_addr_q    <= skid_addr_d;
         skid_data_q    <= skid_data_d;
         skid_en_q      <= skid_en_d;
      end
   end

   // Next-state and slot update; flush overrides every other event.
   always_comb begin
      state_d     = state_q;
      out_addr_d  = w_reg_addr_out;
      out_data_d  = w_reg_data_out;
      out_en_d    = w_reg_en_out;
      skid_addr_d = skid_addr_q;
      skid_data_d = skid_data_q;
      skid_en_d   = skid_en_q;

      case (state_q)
         ST_EMPTY: begin
            if (accept) begin
               out_addr_d = w_reg_addr_in;
               out_data_d = w_reg_data_in;
               out_en_d   = w_reg_en_in;
               state_d    = ST_ONE;
            end
         end
         ST_ONE: begin
            if (accept && pop) begin
               out_addr_d = w_reg_addr_in;
               out_data_d = w_reg_data_in;
               out_en_d   = w_reg_en_in;
            end else if (accept) begin
               skid_addr_d = w_reg_addr_in;
               skid_data_d = w_reg_data_in;
               skid_en_d   = w_reg_en_in;
               state_d     = ST_FULL;
            end else if (pop) begin
               out_en_d = 1'b0;
               state_d  = ST_EMPTY;
            end
         end
         ST_FULL: begin
            if (pop) begin
               out_addr_d = skid_addr_q;
               out_data_d = skid_data_q;
               out_en_d   = skid_en_q;
               state_d    = ST_ONE;
            end
         end
         default: begin
            out_en_d = 1'b0;
            state_d  = ST_EMPTY;
         end
      endcase

      if (flush) begin
         out_en_d = 1'b0;
         state_d  = ST_EMPTY;
      end

      ex_ready_d = (state_d != ST_FULL);
   end

`ifdef EX_MEM_PERF_CNT_EN
   // Saturating count of cycles ex offered a result that could not be taken.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
      end else if (ex_valid && !ex_ready && (stall_cnt != {CNT_W{1'b1}})) begin
         stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_ex_mem_skid.sv
// tb_ex_mem_skid: directed, scoreboard-checked bench for ex_mem_skid.
// The queue models the held entries: its size gives expected mem_valid/ex_ready,
// its head gives the expected output payload.
`timescale 1ns/1ps
module tb_ex_mem_skid;

   typedef struct packed {
      logic [4:0]  a;
      logic [31:0] d;
      logic        e;
   } ent_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic        ex_valid;
   logic        ex_ready;
   logic [4:0]  w_reg_addr_in;
   logic [31:0] w_reg_data_in;
   logic        w_reg_en_in;
   logic        mem_valid;
   logic        mem_ready;
   logic [4:0]  w_reg_addr_out;
   logic [31:0] w_reg_data_out;
   logic        w_reg_en_out;
`ifdef EX_MEM_PERF_CNT_EN
   logic [3:0]  stall_cnt;
`endif

   int checks = 0;
   int errors = 0;
   ent_t sb[$];

   always #5 clk = ~clk;

`ifdef EX_MEM_PERF_CNT_EN
   ex_mem_skid #(.ADDR_W(5), .DATA_W(32), .CNT_W(4)) dut (
`else
   ex_mem_skid #(.ADDR_W(5), .DATA_W(32)) dut (
`endif
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .ex_valid(ex_valid), .ex_ready(ex_ready),
      .w_reg_addr_in(w_reg_addr_in), .w_reg_data_in(w_reg_data_in), .w_reg_en_in(w_reg_en_in),
      .mem_valid(mem_valid), .mem_ready(mem_ready),
      .w_reg_addr_out(w_reg_addr_out), .w_reg_data_out(w_reg_data_out), .w_reg_en_out(w_reg_en_out)
`ifdef EX_MEM_PERF_CNT_EN
      , .stall_cnt(stall_cnt)
`endif
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: drive inputs after a falling edge, check against the model, update the model.
   task automatic step(input logic v, input logic [4:0] a, input logic [31:0] d,
                       input logic e, input logic mr, input logic fl);
      int   n;
      logic rdy;
      ent_t h;
      ex_valid = v; w_reg_addr_in = a; w_reg_data_in = d; w_reg_en_in = e;
      mem_ready = mr; flush = fl;
      #1;
      n   = sb.size();
      rdy = (n < 2);
      chk("ex_ready", 64'(ex_ready), 64'(rdy));
      chk("mem_valid", 64'(mem_valid), 64'(n > 0));
      if (n > 0) begin
         h = sb[0];
         chk("addr_out", 64'(w_reg_addr_out), 64'(h.a));
         chk("data_out", 64'(w_reg_data_out), 64'(h.d));
         chk("en_out", 64'(w_reg_en_out), 64'(h.e));
         if (mr) void'(sb.pop_front());
      end else begin
         chk("en_gated", 64'(w_reg_en_out), 64'(0));
      end
      if (v && rdy && !fl) sb.push_back('{a: a, d: d, e: e});
      if (fl) sb.delete();
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0; flush = 1'b0; ex_valid = 1'b0; mem_ready = 1'b0;
      w_reg_addr_in = '0; w_reg_data_in = '0; w_reg_en_in = 1'b0;
      #2;
      chk("rst_mem_valid", 64'(mem_valid), 64'(0));
      chk("rst_addr", 64'(w_reg_addr_out), 64'(0));
      chk("rst_data", 64'(w_reg_data_out), 64'(0));
      chk("rst_en", 64'(w_reg_en_out), 64'(0));
`ifdef EX_MEM_PERF_CNT_EN
      chk("rst_stall_cnt", 64'(stall_cnt), 64'(0));
`endif
      @(negedge clk);
      rst_n = 1'b1;

      // Single transfer, one-cycle latency.
      step(1'b1, 5'd5, 32'h0000_00FF, 1'b1, 1'b1, 1'b0);
      step(1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 1'b0);

      // Eight back-to-back entries with mem always ready.
      for (int i = 0; i < 8; i++)
         step(1'b1, 5'(i + 3), $urandom, 1'(i), 1'b1, 1'b0);
      step(1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 1'b0);

      // Fill both slots, hold a third entry at ex, then drain in order.
      step(1'b1, 5'd10, 32'hAAAA_0001, 1'b1, 1'b0, 1'b0);
      step(1'b1, 5'd11, 32'hBBBB_0002, 1'b0, 1'b0, 1'b0);
      step(1'b1, 5'd12, 32'hCCCC_0003, 1'b1, 1'b0, 1'b0);
      step(1'b1, 5'd12, 32'hCCCC_0003, 1'b1, 1'b1, 1'b0);
      step(1'b1, 5'd12, 32'hCCCC_0003, 1'b1, 1'b1, 1'b0);
      step(1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 1'b0);
      step(1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 1'b0);

      // Flush while full with an incoming entry.
      step(1'b1, 5'd20, 32'h1111_1111, 1'b1, 1'b0, 1'b0);
      step(1'b1, 5'd21, 32'h2222_2222, 1'b1, 1'b0, 1'b0);
      step(1'b1, 5'd22, 32'h3333_3333, 1'b1, 1'b0, 1'b1);
      step(1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 1'b0);

      // Asynchronous reset in the middle of a full buffer.
      step(1'b1, 5'd30, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0);
      step(1'b1, 5'd31, 32'hCAFE_F00D, 1'b1, 1'b0, 1'b0);
      ex_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("async_mem_valid", 64'(mem_valid), 64'(0));
      chk("async_addr", 64'(w_reg_addr_out), 64'(0));
      chk("async_data", 64'(w_reg_data_out), 64'(0));
      chk("async_en", 64'(w_reg_en_out), 64'(0));
      sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
      step(1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 1'b0);

`ifdef EX_MEM_PERF_CNT_EN
      // Stall counter saturates and survives flush.
      chk("stall_cnt_zero", 64'(stall_cnt), 64'(0));
      step(1'b1, 5'd1, 32'h0000_0001, 1'b1, 1'b0, 1'b0);
      step(1'b1, 5'd2, 32'h0000_0002, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++)
         step(1'b1, 5'd3, 32'h0000_0003, 1'b1, 1'b0, 1'b0);
      chk("stall_cnt_sat", 64'(stall_cnt), 64'(15));
      step(1'b1, 5'd3, 32'h0000_0003, 1'b1, 1'b0, 1'b1);
      #1;
      chk("stall_cnt_flush", 64'(stall_cnt), 64'(15));
      step(1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 1'b0);
`endif

      // Random valid/ready traffic against the model.
      for (int i = 0; i < 60; i++)
         step(1'($urandom_range(0, 1)), 5'($urandom), $urandom, 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0));

      // Bounded drain; anything left behind is lost data.
      for (int i = 0; i < 4 && sb.size() > 0; i++)
         step(1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 1'b0);
      chk("drain_empty", 64'(sb.size()), 64'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
